// File: rtl/vector_exec_pkg.sv
// vector_exec_pkg: shared op/state encodings and beat-count helper for vector_exec_unit
package vector_exec_pkg;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR, ALU_MUL} alu_op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;
  function automatic int calc_beats(input int vector_size, input int num_lanes);
    return (vector_size + num_lanes - 1) / num_lanes;
  endfunction
endpackage

// File: rtl/vector_exec_unit_if.sv
// vector_exec_unit_if: request/response handshake bundle of vector_exec_unit
interface vector_exec_unit_if #(parameter int DATA_WIDTH = 16, parameter int VECTOR_SIZE = 6);
  logic flush;
  logic inValid;
  logic inReady;
  logic [2:0] aluControl;
  logic isScalarInstruction;
  logic isVectorScalarOperation;
  logic [VECTOR_SIZE*DATA_WIDTH-1:0] operand1;
  logic [VECTOR_SIZE*DATA_WIDTH-1:0] operand2;
  logic [DATA_WIDTH-1:0] scalarOperand;
  logic outValid;
  logic outReady;
  logic [VECTOR_SIZE*DATA_WIDTH-1:0] result;
  logic N, Z, V, C;
  logic busy;
  modport slave (
    input flush, inValid, aluControl, isScalarInstruction, isVectorScalarOperation,
          operand1, operand2, scalarOperand, outReady,
    output inReady, outValid, result, N, Z, V, C, busy
  );
  modport master (
    output flush, inValid, aluControl, isScalarInstruction, isVectorScalarOperation,
           operand1, operand2, scalarOperand, outReady,
    input inReady, outValid, result, N, Z, V, C, busy
  );
endinterface

// File: rtl/vector_lane_alu.sv
// vector_lane_alu: combinational single-element ALU with carry/overflow.
// VECTOR_EXEC_SATURATE_EN makes add/sub saturate to the signed range.
module vector_lane_alu import vector_exec_pkg::*; #(parameter int DATA_WIDTH = 16) (
  input  alu_op_e               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  c,
  output logic                  v
);
  logic arith, sub;
  logic [DATA_WIDTH-1:0] bx, logic_y;
  logic [DATA_WIDTH:0] sum;
  always_comb begin
    sub = op == ALU_SUB;
    arith = sub || op == ALU_ADD;
    bx = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + (DATA_WIDTH+1)'(sub);
    c = arith && sum[DATA_WIDTH];
    v = arith && a[DATA_WIDTH-1] == bx[DATA_WIDTH-1] && sum[DATA_WIDTH-1] != a[DATA_WIDTH-1];
    logic_y = op == ALU_AND ? a & b :
              op == ALU_OR  ? a | b :
              op == ALU_XOR ? a ^ b :
              op == ALU_SHL ? a << b[3:0] :
              op == ALU_SHR ? a >> b[3:0] :
              op == ALU_MUL ? a * b : '0;
`ifdef VECTOR_EXEC_SATURATE_EN
    // Overflow can only push away from a's sign, so a's sign picks the rail
    y = !arith ? logic_y :
        !v ? sum[DATA_WIDTH-1:0] :
        a[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
    y = arith ? sum[DATA_WIDTH-1:0] : logic_y;
`endif
  end
endmodule

// File: rtl/vector_exec_unit.sv
// vector_exec_unit: multi-beat vector ALU processing NUM_LANES elements per cycle.
// VECTOR_EXEC_SATURATE_EN (in vector_lane_alu) selects saturating add/sub.
module vector_exec_unit import vector_exec_pkg::*; #(
  parameter int DATA_WIDTH  = 16,
  parameter int VECTOR_SIZE = 6,
  parameter int NUM_LANES   = 2
) (
  input logic clock,
  input logic reset,
  vector_exec_unit_if.slave io
);
  localparam int DW    = DATA_WIDTH;
  localparam int VW    = VECTOR_SIZE * DATA_WIDTH;
  localparam int BEATS = calc_beats(VECTOR_SIZE, NUM_LANES);
  localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
  state_e state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  alu_op_e op_q, op_d;
  logic scalar_q, scalar_d;
  logic [VW-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d;
  flags_t flags_q, flags_d;
  logic [DW-1:0] lane_a [NUM_LANES];
  logic [DW-1:0] lane_b [NUM_LANES];
  logic [DW-1:0] lane_y [NUM_LANES];
  logic lane_c [NUM_LANES];
  logic lane_v [NUM_LANES];
  logic lane_we [NUM_LANES];
  int lane_idx [NUM_LANES];
  logic accept, last;
  assign io.inReady  = !io.flush && (state_q == S_IDLE || (state_q == S_DONE && io.outReady));
  assign accept      = io.inValid && io.inReady;
  assign last        = scalar_q || beat_q == BW'(BEATS-1);
  assign io.outValid = state_q == S_DONE;
  assign io.busy     = state_q != S_IDLE;
  assign io.result   = res_q;
  assign {io.N, io.Z, io.V, io.C} = flags_q;
  // Lanes past the vector end on a partial last beat stay disabled
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_idx[l] = int'(beat_q) * NUM_LANES + l;
      lane_we[l] = state_q == S_RUN && (scalar_q ? l == 0 : lane_idx[l] < VECTOR_SIZE);
      lane_a[l] = op1_q[(lane_we[l] ? lane_idx[l] : 0)*DW +: DW];
      lane_b[l] = op2_q[(lane_we[l] ? lane_idx[l] : 0)*DW +: DW];
    end
  end
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    vector_lane_alu #(.DATA_WIDTH(DW)) u_alu (
      .op(op_q), .a(lane_a[l]), .b(lane_b[l]), .y(lane_y[l]), .c(lane_c[l]), .v(lane_v[l])
    );
  end
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    op_d     = op_q;
    scalar_d = scalar_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    res_d    = res_q;
    flags_d  = flags_q;
    if (io.flush) begin
      state_d = S_IDLE;
      beat_d  = '0;
      res_d   = '0;
      flags_d = '0;
    end else begin
      if (state_q == S_RUN) begin
        for (int l = 0; l < NUM_LANES; l++)
          if (lane_we[l]) res_d[lane_idx[l]*DW +: DW] = lane_y[l];
        if (beat_q == '0)
          flags_d = '{n: lane_y[0][DW-1], z: lane_y[0] == '0, v: lane_v[0], c: lane_c[0]};
        state_d = last ? S_DONE : S_RUN;
        beat_d  = last ? '0 : beat_q + 1'b1;
      end
      if (state_q == S_DONE && io.outReady) state_d = S_IDLE;
      // Operands are latched here so the requester may change them afterwards
      if (accept) begin
        state_d  = S_RUN;
        beat_d   = '0;
        op_d     = alu_op_e'(io.aluControl);
        scalar_d = io.isScalarInstruction;
        op1_d    = io.operand1;
        op2_d    = io.isVectorScalarOperation ? {VECTOR_SIZE{io.scalarOperand}} : io.operand2;
        res_d    = '0;
        flags_d  = '0;
      end
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      op_q     <= ALU_ADD;
      scalar_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      res_q    <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      op_q     <= op_d;
      scalar_q <= scalar_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
    end
  end
endmodule

// File: doc/vector_exec_unit.md
VECTOR_EXEC_UNIT -- requirements
Module: vector_exec_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 16: element width in bits.
REQ-002 Parameter VECTOR_SIZE, default 6: elements per vector (any value >= 1).
REQ-003 Parameter NUM_LANES, default 2: physical ALU lanes (1..VECTOR_SIZE).
REQ-004 Ports, clock and reset first:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low.
- flush  in  1  synchronous abort of the in-flight operation.
- inValid  in  1  request present.
- inReady  out  1  unit accepts the request this cycle.
- aluControl  in  3  operation code.
- isScalarInstruction  in  1  scalar operation on element 0 only.
- isVectorScalarOperation  in  1  broadcast scalarOperand as operand 2.
- operand1  in  VECTOR_SIZE*DATA_WIDTH  vector operand 1; element 0 in the LSBs.
- operand2  in  VECTOR_SIZE*DATA_WIDTH  vector operand 2.
- scalarOperand  in  DATA_WIDTH  broadcast value.
- outValid  out  1  result present.
- outReady  in  1  consumer takes the result.
- result  out  VECTOR_SIZE*DATA_WIDTH  packed result.
- N, Z, V, C  out  1 each  flags of element 0.
- busy  out  1  state is not IDLE.

Function
REQ-005 Transfers occur only when valid and ready are both high in the same cycle. Operands and controls are captured at input acceptance, so the inputs may change afterwards.
REQ-006 aluControl encodings: 000 add, 001 sub (op1-op2), 010 and, 011 or, 100 xor, 101 shl by op2[3:0], 110 logical shr by op2[3:0], 111 low DATA_WIDTH bits of the multiply. All arithmetic wraps modulo 2^DATA_WIDTH.
REQ-007 FSM states:
- IDLE -> RUN on accept.
- RUN -> DONE after the last beat.
- DONE -> IDLE on outReady.
- If inValid is also high in the DONE/outReady cycle, the next request is accepted and the FSM goes straight to RUN.
REQ-008 inReady = (state==IDLE) | (state==DONE & outReady). When flush is high, inReady=0.
REQ-009 Beats in RUN:
- Vector operation: BEATS = ceil(VECTOR_SIZE/NUM_LANES).
- Scalar operation: exactly 1 beat.
- Beat k processes elements k*NUM_LANES .. min((k+1)*NUM_LANES, VECTOR_SIZE)-1.
- On a partial last beat, the excess lanes write nothing.
REQ-010 Latency: outValid rises BEATS cycles after the accept edge. Result and flags are held stable while outValid=1 and outReady=0.
REQ-011 For a scalar operation, result elements 1..VECTOR_SIZE-1 are zero.
REQ-012 Flags are computed on element 0:
- N = MSB; Z = element==0.
- add/sub: C = carry-out (for sub, C = no borrow); V = signed overflow.
- Other operations: C=0, V=0.
REQ-013 flush high in RUN or DONE: the operation is discarded, the state returns to IDLE on the next edge, outValid=0, and result/flags are cleared to zero.
REQ-014 flush outranks every other event in the same cycle, including an accept or an outReady.

Reset
REQ-015 reset low drives asynchronously: state=IDLE, outValid=0, busy=0, result=0, N=Z=V=C=0, beat counter=0.
REQ-016 reset asserted mid-operation aborts the operation. No partial result is ever presented afterwards.

Configuration
REQ-017 Macro VECTOR_EXEC_SATURATE_EN:
- Defined: add/sub saturate per element to the signed range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], and V reports that saturation occurred on element 0.
- Undefined: add/sub wrap as in REQ-006.

Structure
REQ-018 Package vector_exec_pkg holds:
- the aluControl enum;
- the FSM state enum;
- a constant function computing BEATS.
REQ-019 One sub-module, vector_lane_alu: a combinational single-element ALU with carry/overflow outputs, instantiated NUM_LANES times.

Verification
REQ-020 Defaults, vector add, op1 elements 1..6, op2 all 10 -> outValid 3 cycles after accept; result 11..16; N=0, Z=0.
REQ-021 NUM_LANES=4, vector-scalar xor, op1 all 16'hFFFF, scalarOperand 16'h00FF -> 2 beats; all elements 16'hFF00; N=1.
REQ-022 Scalar sub, 5-5 -> 1-beat latency; Z=1, C=1; elements 1..5 = 0.
REQ-023 Scalar add 16'h7FFF+1 -> without the macro: 16'h8000, V=1. With the macro: 16'h7FFF, V=1.
REQ-024 Hold outReady=0 for 4 cycles, then pulse it with a second request pending -> result stable throughout; second request accepted in the same cycle.
REQ-025 flush in beat 2, and separately reset mid-RUN -> IDLE; outValid never asserted; result=0.
